// File: rtl/regfile_scoreboard.sv
// 8-entry register file with writeback bypass and a per-register pending-write
// scoreboard that stalls decode on RAW hazards and pending-counter saturation.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            Read_Reg_1,
  input  logic [2:0]            Read_Reg_2,
  input  logic                  Read_En_1,
  input  logic                  Read_En_2,
  input  logic                  Issue,
  input  logic                  Issue_Write,
  input  logic [2:0]            Write_Reg,
  input  logic                  Write_En,
  input  logic [2:0]            Write_Back_Reg,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data_1,
  output logic [DATA_WIDTH-1:0] Read_Data_2,
  output logic                  Stall,
  output logic [7:0]            Busy,
  output logic                  Err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [8];
  logic [CNT_WIDTH-1:0]  cnt_q  [8];
  logic [CNT_WIDTH-1:0]  cnt_d  [8];
  logic                  err_q, err_d;
  logic                  src1_rdy, src2_rdy, dst_full, stall_raw, acc;
  logic [7:0]            inc_v, dec_v;

  // A source whose only pending write retires this cycle is satisfied by bypass.
  always_comb begin
    src1_rdy = !Read_En_1 || (cnt_q[Read_Reg_1] == '0) ||
               ((cnt_q[Read_Reg_1] == CNT_ONE) && Write_En && (Write_Back_Reg == Read_Reg_1));
    src2_rdy = !Read_En_2 || (cnt_q[Read_Reg_2] == '0) ||
               ((cnt_q[Read_Reg_2] == CNT_ONE) && Write_En && (Write_Back_Reg == Read_Reg_2));
    dst_full = Issue_Write && (cnt_q[Write_Reg] == CNT_MAX) &&
               !(Write_En && (Write_Back_Reg == Write_Reg));
    stall_raw = Issue && (!src1_rdy || !src2_rdy || dst_full);
    acc       = Issue && !stall_raw && Issue_Write;
    Stall     = rst_n && stall_raw;
  end

  always_comb begin
    Read_Data_1 = regs_q[Read_Reg_1];
    Read_Data_2 = regs_q[Read_Reg_2];
    if (Write_En && (Write_Back_Reg == Read_Reg_1)) Read_Data_1 = Write_Data;
    if (Write_En && (Write_Back_Reg == Read_Reg_2)) Read_Data_2 = Write_Data;
    if (!rst_n) begin
      Read_Data_1 = '0;
      Read_Data_2 = '0;
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = cnt_q[r];
      inc_v[r] = acc && (Write_Reg == 3'(r));
      dec_v[r] = Write_En && (Write_Back_Reg == 3'(r)) && (cnt_q[r] != '0);
      if (inc_v[r] && !dec_v[r]) cnt_d[r] = cnt_q[r] + CNT_ONE;
      if (dec_v[r] && !inc_v[r]) cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
    err_d = err_q || (Write_En && (cnt_q[Write_Back_Reg] == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        cnt_q[r] <= cnt_d[r];
        if (Write_En && (Write_Back_Reg == 3'(r))) regs_q[r] <= Write_Data;
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) Busy[r] = (cnt_q[r] != '0);
    Err = err_q;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 8-entry general-purpose register file for the single-issue processor.
- Consumes the destination register number produced by the write-register select stage (Write_Reg).
- Provides two read ports with same-cycle writeback bypass.
- Tracks in-flight destination writes in a per-register pending-count scoreboard and raises Stall on RAW and scoreboard-overflow hazards.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data ports.
- CNT_WIDTH, 2, width of each per-register pending counter; maximum in-flight writes per register = 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Read_Reg_1  input  3  source register A.
- Read_Reg_2  input  3  source register B.
- Read_En_1  input  1  instruction in decode uses source A.
- Read_En_2  input  1  instruction in decode uses source B.
- Issue  input  1  instruction in decode requests issue this cycle.
- Issue_Write  input  1  issuing instruction writes a destination.
- Write_Reg  input  3  destination of the issuing instruction.
- Write_En  input  1  writeback valid this cycle.
- Write_Back_Reg  input  3  writeback destination.
- Write_Data  input  DATA_WIDTH  writeback data.
- Read_Data_1  output  DATA_WIDTH  source A value.
- Read_Data_2  output  DATA_WIDTH  source B value.
- Stall  output  1  decode must hold; issue is blocked.
- Busy  output  8  bit i = 1 when pending count of register i is nonzero.
- Err  output  1  sticky scoreboard-underflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all pending counts = 0, Err = 0. While reset is held: Busy = 0, Stall = 0, Read_Data_x = 0. Reset mid-operation discards all in-flight bookkeeping.
- Reads are combinational.
  - Read_Data_x = Write_Data when Write_En = 1 and Write_Back_Reg == Read_Reg_x (bypass).
  - Otherwise Read_Data_x = stored value.
  - Bypass applies to R0 as well; R0 is an ordinary register.
- Writes: on the rising clk edge, if Write_En = 1, the register at Write_Back_Reg is updated with Write_Data. The write is unconditional, independent of pending count.
- Source ready, for source x: Read_En_x = 0, or count[Read_Reg_x] == 0, or (count[Read_Reg_x] == 1, Write_En = 1 and Write_Back_Reg == Read_Reg_x).
- Stall is combinational and equals Issue AND (any source not ready, OR (Issue_Write = 1 AND count[Write_Reg] == max AND NOT (Write_En = 1 AND Write_Back_Reg == Write_Reg))).
- Accepted issue: acc = Issue AND NOT Stall AND Issue_Write.
- Counter update, per register r, on the rising edge:
  - inc = acc AND Write_Reg == r.
  - dec = Write_En AND Write_Back_Reg == r AND count[r] != 0.
  - inc and not dec: count + 1.
  - dec and not inc: count − 1.
  - both or neither: count unchanged.
  - Counters never wrap; overflow is prevented by Stall.
- Underflow: Write_En = 1 to a register with count == 0:
  - data is still written;
  - count stays 0;
  - Err is set and stays set until reset.
- Busy[r] = (count[r] != 0), registered view; it reflects the post-edge count.
- Latency: a write on edge N is visible in stored-value reads after edge N; in the same cycle it is visible only via bypass.

Test Plan:
- Reset, then read R0..R7 -> all Read_Data = 0, Busy = 8'h00, Stall = 0, Err = 0.
- Write_En=1, Write_Back_Reg=3, Write_Data=16'hBEEF, Read_Reg_1=3 in the same cycle -> Read_Data_1 = 16'hBEEF combinationally; after the edge, Read_Data_1 = 16'hBEEF with Write_En=0.
- Issue, Issue_Write=1, Write_Reg=5 accepted -> Busy=8'h20. Next cycle Issue with Read_En_1=1, Read_Reg_1=5, Write_En=0 -> Stall=1. Same request with Write_En=1, Write_Back_Reg=5, Write_Data=16'h0042 -> Stall=0, Read_Data_1=16'h0042, Busy=8'h00 after the edge.
- Three accepted issues to R2 -> count 3, Busy[2]=1. Fourth issue to R2 with no writeback -> Stall=1. Fourth issue with a simultaneous writeback to R2 -> accepted, count stays 3.
- Write_En=1 to R6 with count 0 -> R6 updated, Err=1 and remains 1 across later cycles until rst_n pulse.
- Assert rst_n=0 asynchronously mid-cycle with R4 busy and holding 16'h1234 -> Busy=0, Read_Data for R4 = 0, Stall=0 immediately, without a clock edge.
